// File: rtl/demux1_4_capture_pkg.sv
// Shared types and constants for the 1:4 byte demultiplexer that captures
// 8051 port writes into atomically committed four-byte frames.
package demux_pkg;

  localparam int DEMUX_WIDTH = 8;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } state_e;

  localparam logic [1:0] SLOT0 = 2'd0;
  localparam logic [1:0] SLOT1 = 2'd1;
  localparam logic [1:0] SLOT2 = 2'd2;
  localparam logic [1:0] SLOT3 = 2'd3;

endpackage : demux_pkg

// File: rtl/demux1_4_capture_if.sv
// Port-side bundle: the 8051 drives din/wr_stb/sync, the capture block drives
// the committed frame and its status pulses.
interface demux1_4_capture_if
  import demux_pkg::*;
#(
  parameter int WIDTH = DEMUX_WIDTH
);

  logic [WIDTH-1:0] din;
  logic             wr_stb;
  logic             sync;
  logic [WIDTH-1:0] o0;
  logic [WIDTH-1:0] o1;
  logic [WIDTH-1:0] o2;
  logic [WIDTH-1:0] o3;
  logic [1:0]       slot;
  logic             frame_valid;
  logic             timeout_err;

  modport master (
    output din, wr_stb, sync,
    input  o0, o1, o2, o3, slot, frame_valid, timeout_err
  );

  modport slave (
    input  din, wr_stb, sync,
    output o0, o1, o2, o3, slot, frame_valid, timeout_err
  );

endinterface : demux1_4_capture_if

// File: rtl/demux1_4_capture_stb_rise_det.sv
// Rising-edge detector for a strobe already synchronous to clk: a held strobe
// yields exactly one single-cycle pulse.
module stb_rise_det (
  input  logic clk,
  input  logic rst,
  input  logic stb,
  output logic rise
);

  logic stb_d;
  logic stb_q;

  always_comb begin
    stb_d = stb;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, independent of block ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      stb_q <= 1'b0;
    end else begin
      stb_q <= stb_d;
    end
  end

  assign rise = stb & ~stb_q;

endmodule : stb_rise_det

// File: rtl/demux1_4_capture.sv
// Distributes a strobed byte stream round-robin into four slots and commits a
// full frame to the output buses in one edge; stalled partial frames time out.
module demux1_4_capture
  import demux_pkg::*;
#(
  parameter int WIDTH          = DEMUX_WIDTH,
  parameter int TIMEOUT_CYCLES = 10000,
  parameter int CNT_W          = 14
) (
  input  logic                clk,
  input  logic                rst,
  demux1_4_capture_if.slave   bus
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic we;

  state_e                      state_d, state_q;
  logic   [1:0]                slot_d, slot_q;
  logic   [CNT_W-1:0]          cnt_d, cnt_q;
  logic   [2:0][WIDTH-1:0]     shadow_d, shadow_q;
  logic   [3:0][WIDTH-1:0]     out_d, out_q;
  logic                        frame_valid_d, frame_valid_q;
  logic                        timeout_err_d, timeout_err_q;

  stb_rise_det u_stb_rise_det (
    .clk  (clk),
    .rst  (rst),
    .stb  (bus.wr_stb),
    .rise (we)
  );

  always_comb begin
    // NOTE: every variable gets its hold value first so no path through the
    // branches below leaves one unassigned, which would infer a latch.
    state_d       = state_q;
    slot_d        = slot_q;
    cnt_d         = cnt_q;
    shadow_d      = shadow_q;
    out_d         = out_q;
    frame_valid_d = 1'b0;
    timeout_err_d = 1'b0;

    if (bus.sync) begin
      // Resync drops any partial frame silently; a coincident write starts the new one.
      cnt_d = '0;
      if (we) begin
        shadow_d[0] = bus.din;
        slot_d      = SLOT1;
        state_d     = FILL;
      end else begin
        slot_d  = SLOT0;
        state_d = IDLE;
      end
    end else if (we) begin
      cnt_d = '0;
      unique case (state_q)
        IDLE: begin
          shadow_d[0] = bus.din;
          slot_d      = SLOT1;
          state_d     = FILL;
        end
        FILL: begin
          unique case (slot_q)
            SLOT1: begin
              shadow_d[1] = bus.din;
              slot_d      = SLOT2;
            end
            SLOT2: begin
              shadow_d[2] = bus.din;
              slot_d      = SLOT3;
            end
            default: begin
              out_d         = {bus.din, shadow_q[2], shadow_q[1], shadow_q[0]};
              frame_valid_d = 1'b1;
              slot_d        = SLOT0;
              state_d       = IDLE;
            end
          endcase
        end
        default: begin
          state_d = IDLE;
          slot_d  = SLOT0;
        end
      endcase
    end else if (state_q == FILL) begin
      // The expiry check caps the count, so the increment can never wrap.
      if (cnt_q == CNT_LAST) begin
        cnt_d         = '0;
        slot_d        = SLOT0;
        state_d       = IDLE;
        timeout_err_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      slot_q        <= SLOT0;
      cnt_q         <= '0;
      // NOTE: the shadow bytes are reset too even though they are always
      // rewritten before a commit; it keeps post-reset state fully defined.
      shadow_q      <= '0;
      out_q         <= '0;
      frame_valid_q <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      slot_q        <= slot_d;
      cnt_q         <= cnt_d;
      shadow_q      <= shadow_d;
      out_q         <= out_d;
      frame_valid_q <= frame_valid_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign bus.o0          = out_q[0];
  assign bus.o1          = out_q[1];
  assign bus.o2          = out_q[2];
  assign bus.o3          = out_q[3];
  assign bus.slot        = slot_q;
  assign bus.frame_valid = frame_valid_q;
  assign bus.timeout_err = timeout_err_q;

endmodule : demux1_4_capture
